inst_fetch_responder: RTL and testbench
=======================================

Name: inst_fetch_responder

Overview:
- Memory-side responder for the program counter's fetch address.
- Accepts a byte fetch address from the PC/fetch stage over a valid/ready handshake and reads the 32-bit instruction from a synchronous backing instruction RAM with fixed read latency.
- Returns the instruction, or an error code, over a valid/ready response channel.
- Holds a one-entry last-fetch register so that re-fetching the same address (stall/replay) skips the RAM.

Parameters:
- DEPTH_LOG2, 14, log2 of instruction RAM depth in 32-bit words.
- MEM_LAT, 2, backing RAM read latency in cycles (legal range 1..4).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_addr  in  32  byte fetch address (PC value).
- req_ready  out  1  request accepted when req_valid && req_ready at posedge.
- flush  in  1  redirect; discard any in-flight or pending response.
- resp_valid  out  1  response valid.
- resp_inst  out  32  fetched instruction.
- resp_err  out  2  00 ok, 01 misaligned, 10 out of range.
- resp_ready  in  1  consumer takes response when resp_valid && resp_ready.
- mem_rd_en  out  1  RAM read strobe, one cycle per read.
- mem_addr  out  DEPTH_LOG2  RAM word address (req_addr[DEPTH_LOG2+1:2]).
- mem_rdata  in  32  RAM data, valid MEM_LAT cycles after the mem_rd_en cycle.

Behaviour:
- Reset values (async on rst_n=0):
  - FSM in IDLE.
  - resp_valid=0, resp_inst=0, resp_err=0.
  - mem_rd_en=0, mem_addr=0.
  - hit-register valid=0, latency counter=0, drop flag=0.
- FSM states: IDLE, BUSY, RESP.
- req_ready = !flush && (IDLE || (RESP && resp_ready)).
- Accept-time classification, in priority order:
  - Misaligned (req_addr[1:0]!=0): resp_err=01.
  - Out of range (req_addr[31:DEPTH_LOG2+2]!=0): resp_err=10.
  - For either error: go to RESP next cycle, resp_inst=32'h00000013 (NOP), no RAM access, hit register untouched.
  - Hit (hit valid && stored addr==req_addr): go to RESP next cycle, resp_inst=stored word, resp_err=00, no RAM access.
  - Miss: go to BUSY. mem_rd_en=1 and mem_addr registered in the first BUSY cycle only. Counter loads MEM_LAT.
- BUSY: counter decrements each cycle after the rd_en cycle. In the cycle mem_rdata is valid (MEM_LAT cycles after rd_en), capture it at the posedge into resp_inst and the hit register (addr, data, valid=1), then go to RESP.
- Latency, accept edge to first resp_valid cycle:
  - Hit or error: 1 cycle.
  - Miss: MEM_LAT+2 cycles.
- RESP: resp_valid=1 with resp_inst/resp_err held stable until resp_ready.
  - On resp_ready with no new accept: go to IDLE, resp_valid=0 next cycle.
  - On resp_ready with a simultaneous new accept: back-to-back transfer, classified as above. A hit or error keeps resp_valid=1 with new data the next cycle.
- flush:
  - In IDLE: no effect; the request in that cycle is not accepted.
  - In RESP: resp_valid=0 next cycle, go to IDLE.
  - In BUSY: set drop flag. On data return, still update the hit register (data is good) but go to IDLE with no resp_valid. The drop flag clears at that point.
  - flush asserted during the data-return cycle also drops that response.
- mem_rd_en is never asserted outside the first BUSY cycle. At most one outstanding RAM read.
- Reset mid-BUSY: RAM data returning after reset is ignored, since the FSM is in IDLE.
- No response is ever lost or duplicated while resp_ready=0.

Decomposition:
- Package inst_fetch_pkg:
  - State encoding (IDLE/BUSY/RESP).
  - Error codes ERR_OK/ERR_MISALIGN/ERR_RANGE.
  - NOP_INST=32'h00000013.
- Sub-module fetch_hit_reg:
  - Holds addr/data/valid.
  - Compare output hit.
  - Write port from the capture path.
  - Cleared on reset only.

Test Plan (MEM_LAT=2):
- Reset, then req_addr=0x0000_0010, RAM word 4=0xDEADBEEF -> mem_rd_en one cycle with mem_addr=4; resp_valid 4 cycles after accept; resp_inst=0xDEADBEEF, resp_err=00.
- Repeat 0x10 immediately after consumption -> no mem_rd_en; resp_valid 1 cycle after accept with 0xDEADBEEF.
- req_addr=0x0000_0012 -> 1-cycle response, resp_err=01, resp_inst=0x00000013, no RAM access. req_addr=0x0001_0000 (DEPTH_LOG2=14) -> resp_err=10.
- Miss to 0x20 with resp_ready held 0 for 5 cycles -> resp_valid and resp_inst stable for all 5 cycles; exactly one transfer when resp_ready rises. Same-cycle accept of a hit for 0x20 -> resp_valid stays 1, back-to-back.
- Miss to 0x30, flush pulsed in the cycle after rd_en -> no resp_valid for that fetch. A subsequent request to 0x30 hits (1-cycle) with the RAM word.
- rst_n dropped during BUSY, released before the data-return cycle -> all outputs at reset values; returning mem_rdata ignored; next request to the same address misses.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared FSM encoding, error codes and NOP word for the fetch responder
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0]  ERR_OK       = 2'b00;
  localparam logic [1:0]  ERR_MISALIGN = 2'b01;
  localparam logic [1:0]  ERR_RANGE    = 2'b10;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch_responder_hit_reg.sv
// fetch_hit_reg: one-entry last-fetch register (addr/data/valid) with hit compare
//   clk, rst_n        : clock, async active-low reset (only way to clear valid)
//   wr_en/addr/data   : capture port driven when RAM data returns
//   rd_addr           : address under lookup
//   hit, data         : lookup result and stored instruction word
module fetch_hit_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_addr,
  output logic        hit,
  output logic [31:0] data
);
  logic        valid;
  logic [31:0] addr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (wr_en) begin
      valid <= 1'b1;
      addr  <= wr_addr;
      data  <= wr_data;
    end
  end
  assign hit = valid && addr == rd_addr;
endmodule

// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: serves PC fetch requests from a fixed-latency instruction RAM
//   clk, rst_n                      : clock, async active-low reset
//   req_valid/req_addr/req_ready    : fetch request handshake (byte address)
//   flush                           : redirect, drops in-flight or pending response
//   resp_valid/inst/err/ready       : response handshake (err 00 ok, 01 misaligned, 10 range)
//   mem_rd_en/mem_addr/mem_rdata    : backing RAM, data valid MEM_LAT cycles after rd_en
module inst_fetch_responder #(
  parameter int DEPTH_LOG2 = 14,
  parameter int MEM_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic [31:0]           resp_inst,
  output logic [1:0]            resp_err,
  input  logic                  resp_ready,
  output logic                  mem_rd_en,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  input  logic [31:0]           mem_rdata
);
  import inst_fetch_pkg::*;

  state_t      state;
  logic [2:0]  cnt;
  logic        drop;
  logic        accept;
  logic        misalign;
  logic        range_err;
  logic        ret;
  logic        hit;
  logic [31:0] hit_data;

  assign req_ready = !flush && (state == S_IDLE || (state == S_RESP && resp_ready));
  assign accept    = req_valid && req_ready;
  assign misalign  = req_addr[1:0] != 2'b00;
  assign range_err = req_addr[31:DEPTH_LOG2+2] != '0;
  // the counter holds through the rd_en cycle, so it reaches 1 exactly in the data-return cycle
  assign ret       = state == S_BUSY && !mem_rd_en && cnt == 3'd1;

  // a captured miss was aligned and in range, so its byte address is the word address shifted back
  fetch_hit_reg u_hit (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ret),
    .wr_addr (32'({mem_addr, 2'b00})),
    .wr_data (mem_rdata),
    .rd_addr (req_addr),
    .hit     (hit),
    .data    (hit_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      resp_valid <= 1'b0;
      resp_inst  <= '0;
      resp_err   <= ERR_OK;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      cnt        <= '0;
      drop       <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      if (accept) begin
        if (misalign || range_err) begin
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_inst  <= NOP_INST;
          resp_err   <= misalign ? ERR_MISALIGN : ERR_RANGE;
        end else if (hit) begin
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_inst  <= hit_data;
          resp_err   <= ERR_OK;
        end else begin
          state      <= S_BUSY;
          resp_valid <= 1'b0;
          mem_rd_en  <= 1'b1;
          mem_addr   <= req_addr[DEPTH_LOG2+1:2];
          cnt        <= 3'(MEM_LAT);
          drop       <= 1'b0;
        end
      end else if (state == S_RESP && (resp_ready || flush)) begin
        state      <= S_IDLE;
        resp_valid <= 1'b0;
      end else if (state == S_BUSY) begin
        if (ret) begin
          drop <= 1'b0;
          if (drop || flush) begin
            state <= S_IDLE;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_inst  <= mem_rdata;
            resp_err   <= ERR_OK;
          end
        end else begin
          if (flush) drop <= 1'b1;
          if (!mem_rd_en) cnt <= cnt - 3'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_responder.sv
// tb_inst_fetch_responder: randomized self-checking bench against a transaction-level fetch model
module tb_inst_fetch_responder;
  localparam int DL = 14;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [31:0]   req_addr = '0;
  logic          req_ready;
  logic          flush = 1'b0;
  logic          resp_valid;
  logic [31:0]   resp_inst;
  logic [1:0]    resp_err;
  logic          resp_ready = 1'b0;
  logic          mem_rd_en;
  logic [DL-1:0] mem_addr;
  logic [31:0]   mem_rdata;

  int pass_cnt = 0;
  int total = 0;

  logic [31:0] ram [0:(1<<DL)-1];
  logic [31:0] pipe [0:ML-1];
  logic        hv;
  logic [31:0] ha, hd;

  inst_fetch_responder #(.DEPTH_LOG2(DL), .MEM_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .flush(flush), .resp_valid(resp_valid),
    .resp_inst(resp_inst), .resp_err(resp_err), .resp_ready(resp_ready),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = ML - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= mem_rd_en ? ram[mem_addr] : $urandom;
  end
  assign mem_rdata = pipe[ML-1];

  // expected result of a fetch from an idle responder, updating the modelled last-fetch entry
  task automatic model(input logic [31:0] a, output int e_lat, output int e_rd,
                       output logic [31:0] e_inst, output logic [1:0] e_err);
    if (a[1:0] != 2'b00) begin
      e_lat = 1; e_rd = 0; e_inst = 32'h13; e_err = 2'b01;
    end else if (a >= (32'd1 << (DL + 2))) begin
      e_lat = 1; e_rd = 0; e_inst = 32'h13; e_err = 2'b10;
    end else if (hv && ha == a) begin
      e_lat = 1; e_rd = 0; e_inst = hd; e_err = 2'b00;
    end else begin
      e_lat = ML + 2; e_rd = 1; e_inst = ram[a / 4]; e_err = 2'b00;
      hv = 1'b1; ha = a; hd = e_inst;
    end
  endtask

  // one request from idle, waits for its response, then consumes it
  task automatic fetch(input logic [31:0] a, output int lat, output int rd,
                       output logic [DL-1:0] ma, output logic [31:0] inst, output logic [1:0] err);
    int n;
    @(negedge clk); req_valid = 1'b1; req_addr = a; resp_ready = 1'b0; #1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk); req_valid = 1'b0;
    lat = 1; rd = 0; ma = '0;
    while (!resp_valid && lat < 20) begin
      if (mem_rd_en) begin rd++; ma = mem_addr; end
      @(negedge clk); lat++;
    end
    inst = resp_inst; err = resp_err;
    if (!resp_valid) lat = -1;
    resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b exp 0", resp_valid); else pass_cnt++;
    total++; if (resp_inst !== 32'h0) $display("FAIL reset_resp_inst got %h exp 0", resp_inst); else pass_cnt++;
    total++; if (resp_err !== 2'b00) $display("FAIL reset_resp_err got %b exp 00", resp_err); else pass_cnt++;
    total++; if (mem_rd_en !== 1'b0) $display("FAIL reset_mem_rd_en got %b exp 0", mem_rd_en); else pass_cnt++;
    total++; if (mem_addr !== '0) $display("FAIL reset_mem_addr got %h exp 0", mem_addr); else pass_cnt++;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_miss;
    int lat, rd; logic [DL-1:0] ma; logic [31:0] inst; logic [1:0] err;
    fetch(32'h10, lat, rd, ma, inst, err);
    hv = 1'b1; ha = 32'h10; hd = 32'hDEADBEEF;
    total++; if (lat != ML + 2) $display("FAIL miss_latency got %0d exp %0d", lat, ML + 2); else pass_cnt++;
    total++; if (rd != 1) $display("FAIL miss_rd_en_count got %0d exp 1", rd); else pass_cnt++;
    total++; if (ma !== 14'd4) $display("FAIL miss_mem_addr got %h exp 4", ma); else pass_cnt++;
    total++; if (inst !== 32'hDEADBEEF) $display("FAIL miss_inst got %h exp deadbeef", inst); else pass_cnt++;
    total++; if (err !== 2'b00) $display("FAIL miss_err got %b exp 00", err); else pass_cnt++;
    total++; if (resp_valid !== 1'b0) $display("FAIL miss_valid_after_take got %b exp 0", resp_valid); else pass_cnt++;
  endtask

  task automatic test_hit;
    int lat, rd; logic [DL-1:0] ma; logic [31:0] inst; logic [1:0] err;
    fetch(32'h10, lat, rd, ma, inst, err);
    total++; if (lat != 1) $display("FAIL hit_latency got %0d exp 1", lat); else pass_cnt++;
    total++; if (rd != 0) $display("FAIL hit_rd_en_count got %0d exp 0", rd); else pass_cnt++;
    total++; if (inst !== 32'hDEADBEEF) $display("FAIL hit_inst got %h exp deadbeef", inst); else pass_cnt++;
  endtask

  task automatic test_errors;
    logic [31:0] addrs [2];
    logic [1:0]  codes [2];
    int lat, rd; logic [DL-1:0] ma; logic [31:0] inst; logic [1:0] err;
    addrs[0] = 32'h12;      codes[0] = 2'b01;
    addrs[1] = 32'h1_0000;  codes[1] = 2'b10;
    for (int i = 0; i < 2; i++) begin
      fetch(addrs[i], lat, rd, ma, inst, err);
      total++; if (lat != 1 || rd != 0) $display("FAIL err_timing addr %h got lat %0d rd %0d exp lat 1 rd 0", addrs[i], lat, rd); else pass_cnt++;
      total++; if (inst !== 32'h13) $display("FAIL err_inst addr %h got %h exp 00000013", addrs[i], inst); else pass_cnt++;
      total++; if (err !== codes[i]) $display("FAIL err_code addr %h got %b exp %b", addrs[i], err, codes[i]); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    int n; logic ok; logic [31:0] exp_inst;
    exp_inst = ram[8];
    @(negedge clk); req_valid = 1'b1; req_addr = 32'h20; resp_ready = 1'b0;
    @(negedge clk); req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    hv = 1'b1; ha = 32'h20; hd = exp_inst;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid !== 1'b1 || resp_inst !== exp_inst || resp_err !== 2'b00) ok = 1'b0;
      @(negedge clk);
    end
    total++; if (ok !== 1'b1 || resp_inst !== exp_inst) $display("FAIL stall_hold got valid %b inst %h exp valid 1 inst %h", resp_valid, resp_inst, exp_inst); else pass_cnt++;
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h20; #1;
    total++; if (req_ready !== 1'b1) $display("FAIL b2b_req_ready got %b exp 1", req_ready); else pass_cnt++;
    @(negedge clk); req_valid = 1'b0;
    total++; if (resp_valid !== 1'b1 || resp_inst !== exp_inst) $display("FAIL b2b_hit got valid %b inst %h exp valid 1 inst %h", resp_valid, resp_inst, exp_inst); else pass_cnt++;
    @(negedge clk); resp_ready = 1'b0;
    total++; if (resp_valid !== 1'b0) $display("FAIL b2b_single_transfer got valid %b exp 0", resp_valid); else pass_cnt++;
  endtask

  task automatic test_flush;
    int seen; int lat, rd; logic [DL-1:0] ma; logic [31:0] inst; logic [1:0] err;
    @(negedge clk); req_valid = 1'b1; req_addr = 32'h30;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin if (resp_valid) seen++; @(negedge clk); end
    hv = 1'b1; ha = 32'h30; hd = ram[12];
    total++; if (seen != 0) $display("FAIL flush_drop got %0d valid cycles exp 0", seen); else pass_cnt++;
    fetch(32'h30, lat, rd, ma, inst, err);
    total++; if (lat != 1 || rd != 0) $display("FAIL flush_refetch_hit got lat %0d rd %0d exp lat 1 rd 0", lat, rd); else pass_cnt++;
    total++; if (inst !== ram[12]) $display("FAIL flush_refetch_inst got %h exp %h", inst, ram[12]); else pass_cnt++;
  endtask

  task automatic test_reset_busy;
    int seen; int lat, rd; logic [DL-1:0] ma; logic [31:0] inst; logic [1:0] err;
    @(negedge clk); req_valid = 1'b1; req_addr = 32'h40;
    @(negedge clk); req_valid = 1'b0;
    total++; if (mem_rd_en !== 1'b1) $display("FAIL rbusy_rd_en got %b exp 1", mem_rd_en); else pass_cnt++;
    rst_n = 1'b0; #1;
    total++; if (resp_valid !== 1'b0 || resp_inst !== 32'h0 || resp_err !== 2'b00 || mem_rd_en !== 1'b0 || mem_addr !== '0)
      $display("FAIL rbusy_outputs got valid %b inst %h err %b rd %b addr %h exp all zero", resp_valid, resp_inst, resp_err, mem_rd_en, mem_addr);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    hv = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin if (resp_valid) seen++; @(negedge clk); end
    total++; if (seen != 0) $display("FAIL rbusy_ignored got %0d valid cycles exp 0", seen); else pass_cnt++;
    fetch(32'h40, lat, rd, ma, inst, err);
    hv = 1'b1; ha = 32'h40; hd = ram[16];
    total++; if (lat != ML + 2 || rd != 1) $display("FAIL rbusy_refetch_miss got lat %0d rd %0d exp lat %0d rd 1", lat, rd, ML + 2); else pass_cnt++;
    total++; if (inst !== ram[16]) $display("FAIL rbusy_refetch_inst got %h exp %h", inst, ram[16]); else pass_cnt++;
  endtask

  task automatic test_random;
    logic [31:0] a, prev;
    int lat, rd, e_lat, e_rd; logic [DL-1:0] ma; logic [31:0] inst, e_inst; logic [1:0] err, e_err;
    prev = 32'h40;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 7)) << 2;
        6:                a = prev;
        7:                a = ($urandom & 32'hFFFC) | 32'($urandom_range(1, 3));
        8:                a = ($urandom & 32'hFFFF_FFFC) | 32'h0001_0000;
        default:          a = $urandom & 32'hFFFC;
      endcase
      prev = a;
      model(a, e_lat, e_rd, e_inst, e_err);
      fetch(a, lat, rd, ma, inst, err);
      total++;
      if (lat != e_lat || rd != e_rd || inst !== e_inst || err !== e_err || (e_rd == 1 && ma !== a[DL+1:2]))
        $display("FAIL rand addr %h got lat %0d rd %0d ma %h inst %h err %b exp lat %0d rd %0d inst %h err %b",
                 a, lat, rd, ma, inst, err, e_lat, e_rd, e_inst, e_err);
      else pass_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << DL); i++) ram[i] = $urandom;
    ram[4] = 32'hDEADBEEF;
    for (int i = 0; i < ML; i++) pipe[i] = '0;
    hv = 1'b0; ha = '0; hd = '0;
    repeat (2) @(negedge clk);
    test_reset;
    test_miss;
    test_hit;
    test_errors;
    test_back_to_back;
    test_flush;
    test_reset_busy;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
